// File: rtl/pcfa_pkg.sv
// rtl/pcfa_pkg.sv - shared types and constants for the slice-serial subtractor
package pcfa_pkg;

  localparam int PCFA_WIDTH = 8;
  localparam int PCFA_SLICE = 4;

  // Bit positions inside the {N,Z,C,V} flags word
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/pcfa_slice.sv
// rtl/pcfa_slice.sv - combinational SLICE-bit ripple-carry adder slice
module pcfa_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout
);

  logic c;

  always_comb begin
    c   = cin;
    sum = '0;
    for (int k = 0; k < SLICE; k++) begin
      sum[k] = a[k] ^ b[k] ^ c;
      c      = (a[k] & b[k]) | (c & (a[k] ^ b[k]));
    end
    cout = c;
  end

endmodule

// File: rtl/pcfa_sub_mc.sv
// rtl/pcfa_sub_mc.sv - multicycle slice-serial A - B - bin with start/busy/done
// Optional {N,Z,C,V} flags port enabled by defining PCFA_SUB_FLAGS_EN.
module pcfa_sub_mc
  import pcfa_pkg::*;
#(
  parameter int WIDTH = PCFA_WIDTH,
  parameter int SLICE = PCFA_SLICE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             bout
`ifdef PCFA_SUB_FLAGS_EN
  ,
  output logic [3:0]       flags
`endif
);

  localparam int N   = WIDTH / SLICE;
  localparam int IW  = (N > 1) ? $clog2(N) : 1;
  localparam int MSB = WIDTH - 1;

  state_t           state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] nb_r;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] diff_next;
  logic             carry;
  logic [SLICE-1:0] s_sum;
  logic             s_cout;
  logic             last;

  assign last = (idx == IW'(N - 1));

  pcfa_slice #(.SLICE(SLICE)) u_slice (
    .a    (a_r[idx*SLICE +: SLICE]),
    .b    (nb_r[idx*SLICE +: SLICE]),
    .cin  (carry),
    .sum  (s_sum),
    .cout (s_cout)
  );

  // Shadow accumulator with the current slice merged in; becomes Diff on the last slice
  always_comb begin
    diff_next = shadow;
    diff_next[idx*SLICE +: SLICE] = s_sum;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      a_r    <= '0;
      nb_r   <= '0;
      shadow <= '0;
      carry  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      Diff   <= '0;
      bout   <= 1'b0;
`ifdef PCFA_SUB_FLAGS_EN
      flags  <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_r   <= A;
            nb_r  <= ~B;
            carry <= ~bin;
            idx   <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          shadow <= diff_next;
          carry  <= s_cout;
          idx    <= idx + 1'b1;
          if (last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            Diff  <= diff_next;
            bout  <= ~s_cout;
`ifdef PCFA_SUB_FLAGS_EN
            flags[FLAG_N] <= diff_next[MSB];
            flags[FLAG_Z] <= (diff_next == '0);
            flags[FLAG_C] <= s_cout;
            // nb_r holds ~B, so A and B differ in sign exactly when a_r and nb_r agree
            flags[FLAG_V] <= (a_r[MSB] == nb_r[MSB]) && (diff_next[MSB] != a_r[MSB]);
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pcfa_sub_mc.sv
// tb/tb_pcfa_sub_mc.sv - self-checking bench for pcfa_sub_mc (WIDTH=8, SLICE=4)
module tb_pcfa_sub_mc;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] A;
  logic [7:0] B;
  logic       bin;
  logic       busy;
  logic       done;
  logic [7:0] Diff;
  logic       bout;
`ifdef PCFA_SUB_FLAGS_EN
  logic [3:0] flags;
`endif

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] held     = 8'h00;

  always #5 clk = ~clk;

  pcfa_sub_mc dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .Diff  (Diff),
    .bout  (bout)
`ifdef PCFA_SUB_FLAGS_EN
    ,
    .flags (flags)
`endif
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bi;
    logic [7:0] diff;
    logic       bo;
    logic [3:0] fl;
    bit         poke;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands, flags from signed range
  task automatic model(input logic [7:0] a, input logic [7:0] b, input logic bi,
                       output logic [7:0] d, output logic bo, output logic [3:0] f);
    int r;
    int sr;
    r  = int'(a) - int'(b) - int'(bi);
    sr = int'($signed(a)) - int'($signed(b)) - int'(bi);
    d  = r[7:0];
    bo = (r < 0);
    f  = {d[7], (d == 8'h00), ~bo, ((sr < -128) || (sr > 127))};
  endtask

  // Starts at a negedge, returns at the negedge where done is seen
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic bi, input logic [7:0] ed, input logic eb,
                        input logic [3:0] ef, input bit poke);
    int lat;
    A = a; B = b; bin = bi; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    A = 8'($urandom); B = 8'($urandom); bin = 1'($urandom);
    lat = 1;
    while (!done && lat < 10) begin
      chk({tag, " busy"}, 32'(busy), 32'd1);
      chk({tag, " hold"}, 32'(Diff), 32'(held));
      if (poke && lat == 1) begin
        start = 1'b1;
        A = 8'h00;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk({tag, " latency"}, 32'(lat), 32'd3);
    chk({tag, " busy_at_done"}, 32'(busy), 32'd0);
    chk({tag, " diff"}, 32'(Diff), 32'(ed));
    chk({tag, " bout"}, 32'(bout), 32'(eb));
`ifdef PCFA_SUB_FLAGS_EN
    chk({tag, " flags"}, 32'(flags), 32'(ef));
`else
    if (ef === 4'hx) $display("flags %0h", ef);
`endif
    held = ed;
  endtask

  initial begin
    logic [7:0] ra, rb, ed;
    logic       rbi, eb;
    logic [3:0] ef;
    int         seen;

    vecs[0] = '{8'h04, 8'h04, 1'b0, 8'h00, 1'b0, 4'b0110, 1'b0};
    vecs[1] = '{8'h01, 8'h02, 1'b0, 8'hFF, 1'b1, 4'b1000, 1'b0};
    vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 4'b0011, 1'b0};
    vecs[3] = '{8'hFF, 8'h02, 1'b0, 8'hFD, 1'b0, 4'b1010, 1'b0};
    vecs[4] = '{8'h05, 8'h03, 1'b1, 8'h01, 1'b0, 4'b0010, 1'b1};
    vecs[5] = '{8'h7F, 8'h80, 1'b1, 8'hFE, 1'b1, 4'b1001, 1'b0};

    rst = 1'b1; start = 1'b0; A = 8'h00; B = 8'h00; bin = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset diff", 32'(Diff), 32'd0);
    chk("reset bout", 32'(bout), 32'd0);
`ifdef PCFA_SUB_FLAGS_EN
    chk("reset flags", 32'(flags), 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].bi,
             vecs[i].diff, vecs[i].bo, vecs[i].fl, vecs[i].poke);
      @(negedge clk);
      chk($sformatf("vec%0d done_pulse", i), 32'(done), 32'd0);
      chk($sformatf("vec%0d diff_held", i), 32'(Diff), 32'(vecs[i].diff));
    end

    // Back-to-back: second start issued in the done cycle
    run_op("b2b0", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 4'b0010, 1'b0);
    run_op("b2b1", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 4'b1000, 1'b0);

    // Reset asserted in the second CALC cycle
    A = 8'h55; B = 8'h11; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort diff", 32'(Diff), 32'd0);
    chk("abort bout", 32'(bout), 32'd0);
    held = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (done || busy) seen = 1;
    end
    chk("abort no_done", 32'(seen), 32'd0);
    run_op("after_abort", 8'h09, 8'h04, 1'b0, 8'h05, 1'b0, 4'b0010, 1'b0);

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rbi = 1'($urandom);
      if (i == 0) begin ra = 8'h00; rb = 8'hFF; rbi = 1'b1; end
      if (i == 1) begin ra = 8'h80; rb = 8'h00; rbi = 1'b1; end
      model(ra, rb, rbi, ed, eb, ef);
      run_op($sformatf("rnd%0d", i), ra, rb, rbi, ed, eb, ef, 1'b0);
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
